stopwatch_counter: RTL and testbench

Minutes/seconds stopwatch core for the clock/stopwatch datapath. It counts MM:SS from 1 Hz ticks, supports a pause toggle, and has an adjust mode that fast-advances the selected field at 2 Hz. It runs in the single system clock domain. Slow tick inputs and the pause button are synchronised and edge-detected internally. Outputs feed the display/BCD stage directly.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/stopwatch_counter_if.sv | 23 ++
 rtl/stopwatch_counter_sync_edge.sv | 47 ++++
 rtl/stopwatch_counter.sv | 82 ++++++++
 tb/tb_stopwatch_counter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared widths, limits and helpers for the MM:SS stopwatch datapath.
package stopwatch_pkg;

  localparam int TIME_W = 6;

  typedef logic [TIME_W-1:0] time_t;

  typedef enum logic {
    FIELD_MIN = 1'b0,
    FIELD_SEC = 1'b1
  } field_e;

  localparam time_t MAX_SEC = 6'd59;
  localparam time_t MAX_MIN = 6'd59;

  // Increment with wrap to zero once the field limit is reached.
  function automatic time_t wrap_inc(input time_t value, input time_t max_value);
    return (value == max_value) ? '0 : value + time_t'(1);
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control/tick inputs and MM:SS outputs of the stopwatch core.
interface stopwatch_counter_if;
  import stopwatch_pkg::*;

  logic  clk_1Hz;
  logic  clk_2Hz;
  logic  pse;
  logic  adj;
  logic  sel;
  time_t min;
  time_t sec;

  modport master (
    output clk_1Hz, clk_2Hz, pse, adj, sel,
    input  min, sec
  );

  modport slave (
    input  clk_1Hz, clk_2Hz, pse, adj, sel,
    output min, sec
  );

endinterface

// File: rtl/stopwatch_counter_sync_edge.sv
// Multi-stage synchroniser for a slow asynchronous level, plus a one-cycle
// pulse on each rising edge of the synchronised signal.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   prev_reg;
  // Counts the cycles since reset until both the synchroniser output and the
  // edge history hold real post-reset samples; a level already high at
  // release therefore never looks like a rising edge.
  logic [SYNC_STAGES:0]   fill_reg;
  logic                   armed;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_next[gi] = din;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      fill_reg <= '0;
    end else begin
      sync_reg <= sync_next;
      prev_reg <= sync_reg[SYNC_STAGES-1];
      fill_reg <= {fill_reg[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign armed = fill_reg[SYNC_STAGES];
  assign pulse = armed & sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: 1 Hz counting with pause toggle, and a 2 Hz adjust
// mode that advances the selected field without carry.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  stopwatch_counter_if.slave  bus
);

  logic  t1;
  logic  t2;
  logic  tp;

  logic  pause_reg;
  logic  pause_next;
  time_t min_reg;
  time_t min_next;
  time_t sec_reg;
  time_t sec_next;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_1hz (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.clk_1Hz),
    .pulse (t1)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_2hz (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.clk_2Hz),
    .pulse (t2)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pse (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.pse),
    .pulse (tp)
  );

  // Counting reads the current pause flag, so a toggle landing together
  // with a tick only takes effect from the following cycle.
  always_comb begin
    pause_next = pause_reg ^ tp;
    min_next   = min_reg;
    sec_next   = sec_reg;
    if (bus.adj) begin
      if (t2) begin
        if (bus.sel == FIELD_SEC) begin
          sec_next = wrap_inc(sec_reg, MAX_SEC);
        end else begin
          min_next = wrap_inc(min_reg, MAX_MIN);
        end
      end
    end else if (t1 && !pause_reg) begin
      sec_next = wrap_inc(sec_reg, MAX_SEC);
      if (sec_reg == MAX_SEC) begin
        min_next = wrap_inc(min_reg, MAX_MIN);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pause_reg <= 1'b0;
      min_reg   <= '0;
      sec_reg   <= '0;
    end else begin
      pause_reg <= pause_next;
      min_reg   <= min_next;
      sec_reg   <= sec_next;
    end
  end

  assign bus.min = min_reg;
  assign bus.sec = sec_reg;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: counting, pause, adjust, wrap, reset.
module tb_stopwatch_counter;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  stopwatch_counter_if sw_if ();

  stopwatch_counter #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // which: 0 = clk_1Hz, 1 = clk_2Hz, 2 = pse, 3 = clk_1Hz and pse together
  task automatic pulse_in(input int which, input int count);
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      if (which == 0 || which == 3) sw_if.clk_1Hz = 1'b1;
      if (which == 1)               sw_if.clk_2Hz = 1'b1;
      if (which == 2 || which == 3) sw_if.pse     = 1'b1;
      repeat (6) @(negedge clk);
      sw_if.clk_1Hz = 1'b0;
      sw_if.clk_2Hz = 1'b0;
      sw_if.pse     = 1'b0;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic check_time(input string tag, input int exp_min, input int exp_sec);
    n_total++;
    assert (sw_if.min === 6'(exp_min) && sw_if.sec === 6'(exp_sec))
      n_pass++;
    else
      $error("FAIL %s: observed %0d:%0d expected %0d:%0d",
             tag, sw_if.min, sw_if.sec, exp_min, exp_sec);
    $display("check %-22s observed %02d:%02d expected %02d:%02d",
             tag, sw_if.min, sw_if.sec, exp_min, exp_sec);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b0;
    sw_if.clk_1Hz = 1'b0;
    sw_if.clk_2Hz = 1'b0;
    sw_if.pse     = 1'b0;
    sw_if.adj     = 1'b0;
    sw_if.sel     = 1'b0;

    do_reset();
    check_time("reset", 0, 0);

    pulse_in(0, 10);
    check_time("count_10", 0, 10);

    pulse_in(2, 1);
    pulse_in(0, 5);
    check_time("paused_hold", 0, 10);
    pulse_in(2, 1);
    pulse_in(0, 15);
    check_time("resumed_15", 0, 25);

    // Pause toggle together with a tick: tick still counts, then paused.
    pulse_in(3, 1);
    check_time("tp_t1_same_cycle", 0, 26);
    pulse_in(0, 2);
    check_time("paused_after_tp", 0, 26);

    do_reset();
    pulse_in(0, 10);
    pulse_in(2, 1);
    sw_if.adj = 1'b1;
    sw_if.sel = 1'b0;
    pulse_in(1, 20);
    check_time("adj_min_20", 20, 10);
    pulse_in(0, 3);
    check_time("adj_ignores_t1", 20, 10);
    sw_if.sel = 1'b1;
    pulse_in(1, 20);
    check_time("adj_sec_20", 20, 30);
    pulse_in(1, 30);
    check_time("adj_sec_wrap", 20, 0);
    sw_if.adj = 1'b0;
    pulse_in(0, 2);
    check_time("still_paused", 20, 0);
    pulse_in(2, 1);
    pulse_in(0, 15);
    check_time("unpause_15", 20, 15);

    do_reset();
    check_time("reset_again", 0, 0);
    pulse_in(0, 70);
    check_time("count_70", 1, 10);

    do_reset();
    sw_if.adj = 1'b1;
    sw_if.sel = 1'b0;
    pulse_in(1, 59);
    sw_if.sel = 1'b1;
    pulse_in(1, 58);
    check_time("preload_5958", 59, 58);
    sw_if.adj = 1'b0;
    pulse_in(0, 1);
    check_time("count_5959", 59, 59);
    pulse_in(0, 1);
    check_time("wrap_0000", 0, 0);

    do_reset();
    sw_if.adj = 1'b1;
    sw_if.sel = 1'b0;
    pulse_in(1, 12);
    sw_if.sel = 1'b1;
    pulse_in(1, 33);
    sw_if.adj = 1'b0;
    pulse_in(0, 1);
    check_time("count_1234", 12, 34);
    pulse_in(2, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_time("rst_mid_count", 0, 0);
    repeat (4) @(negedge clk);
    pulse_in(0, 1);
    check_time("rst_clears_pause", 0, 1);

    // Reset sampled in the same cycle as the t1 pulse; the input stays high
    // across release and must not produce a tick afterwards.
    @(negedge clk);
    sw_if.clk_1Hz = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_time("rst_with_t1", 0, 0);
    repeat (8) @(negedge clk);
    check_time("high_at_release", 0, 0);
    sw_if.clk_1Hz = 1'b0;
    repeat (6) @(negedge clk);
    pulse_in(0, 1);
    check_time("first_tick_after_rst", 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
